pad_filter: RTL and testbench
=============================

Name: pad_filter

Overview:
- Inverse of the crop stage: accepts a raster-ordered stream of a cropped IN_ROWS x IN_COLS sub-image.
- Re-embeds it at offset (Y_1, X_1) inside a full OUT_ROWS x OUT_COLS frame and emits PAD_VALUE at every position outside the window.
- Sits downstream of the crop stage to restore full-frame geometry for display/compare paths.
- Valid/ready on both sides, with a registered output stage.

Parameters:
PIXEL_BIT_WIDTH, 12, bits per pixel
IN_ROWS, 20, rows of the incoming cropped image
IN_COLS, 20, columns of the incoming cropped image
OUT_ROWS, 40, rows of the emitted full frame
OUT_COLS, 40, columns of the emitted full frame
Y_1, 10, first output row occupied by input row 0
X_1, 10, first output column occupied by input column 0
PAD_VALUE, 0, pixel value emitted outside the window
(legal iff Y_1+IN_ROWS <= OUT_ROWS and X_1+IN_COLS <= OUT_COLS)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
pixel_in  input  PIXEL_BIT_WIDTH  cropped pixel data
in_valid  input  1  pixel_in valid
in_ready  output  1  block accepts pixel_in this cycle
pixel_out  output  PIXEL_BIT_WIDTH  full-frame pixel (registered)
out_valid  output  1  pixel_out valid (registered)
out_ready  input  1  downstream accepts pixel_out
out_last  output  1  high with final pixel of a frame (registered)

Behaviour:
- Reset (reset==0, immediate, no clock edge needed):
  - pixel_out=0, out_valid=0, out_last=0.
  - Coordinates x=y=0, state IDLE.
- Coordinates: x counts 0..OUT_COLS-1 and y counts 0..OUT_ROWS-1, each of width $clog2(max+1). They name the next position to load into the output register.
- in_win = (y>=Y_1) && (y<Y_1+IN_ROWS) && (x>=X_1) && (x<X_1+IN_COLS).
- slot_free = !out_valid || out_ready.
- States:
  - IDLE:
    - in_ready=0; nothing loaded.
    - in_valid==1 → ACTIVE next cycle. The pixel is not consumed in IDLE.
  - ACTIVE, load rules:
    - in_win: in_ready = slot_free. Load occurs iff slot_free && in_valid: pixel_out<=pixel_in.
    - !in_win: in_ready=0. Load occurs iff slot_free: pixel_out<=PAD_VALUE. Padding needs no input.
    - On load: out_valid<=1; out_last<=(x==OUT_COLS-1 && y==OUT_ROWS-1); advance x, wrapping at OUT_COLS-1 and incrementing y.
    - On loading the last position: x<=0, y<=0, state<=IDLE.
    - No load && out_ready: out_valid<=0, out_last<=0.
    - No load && !out_ready: hold all registers.
- Latency: one cycle from load to out_valid. Sustained 1 pixel/clk when out_ready=1 and input keeps up.
- Backpressure: while out_valid && !out_ready, pixel_out, out_valid, out_last, x, y and in_ready=0 are all stable.
- Input gap inside window: counters hold, output bubbles after drain. Padding is never emitted in place of a window pixel.
- Frame wrap: after the last load, the block returns to IDLE. The next frame's first pixel costs one IDLE→ACTIVE cycle.
- Reset mid-frame: the partial frame is discarded. The next frame starts at (0,0) on the next in_valid.
- Reset released while in_valid=1: IDLE→ACTIVE on the first clock after release.

Decomposition:
- Shared package crop_pkg:
  - coordinate width function (clog2(N+1)).
  - state encoding localparams IDLE/ACTIVE.
  - window-compare function, also used by crop_filter.
- Sub-module raster_counter:
  - Parameters COLS, ROWS.
  - Ports: clk, reset, incr, x, y, frame_end.
  - Async active-low clear, wraps on frame end.

Test Plan (IN 2x2, OUT 4x4, Y_1=1, X_1=1, PAD_VALUE=12'hFFF unless noted):
- Basic frame, out_ready=1, pixels 1,2,3,4 presented with in_valid=1 → 16 outputs: FFF×5,1,2,FFF,FFF,3,4,FFF×5; out_last only on the 16th; in_ready high exactly 4 cycles.
- Backpressure: out_ready=0 for 3 cycles on output index 5 → pixel_out=1 held, in_ready=0, x/y unchanged; full sequence identical once released.
- Input gap: in_valid=0 for 4 cycles before pixel 3 → output stalls after index 8 with no FFF inserted; resumes with 3,4.
- Reset mid-frame: assert reset after output index 6 → same-cycle out_valid=0, pixel_out=0; the next frame reproduces the full 16-pixel sequence from index 0.
- Back-to-back frames: 8 input pixels continuous → 32 outputs, out_last on 16th and 32nd, exactly one IDLE bubble between frames.
- Pass-through: IN=OUT=4x4, Y_1=X_1=0, inputs 0..15 → outputs 0..15 in order, no padding, out_last on 15.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared crop/pad definitions: FSM encoding, coordinate sizing and the
// window membership test used by both crop_filter and pad_filter.
package crop_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Width of a counter that must hold values 0..max_val (never less than 1 bit).
  function automatic int coord_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic in_window(input int y, input int x,
                                     input int y1, input int rows,
                                     input int x1, input int cols);
    return (y >= y1) && (y < y1 + rows) && (x >= x1) && (x < x1 + cols);
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x fastest) position counter; frame_end flags the final
// position and the counter wraps to (0,0) when it advances past it.
module raster_counter
  import crop_pkg::*;
#(
  parameter int  COLS = 40,
  parameter int  ROWS = 40,
  localparam int XW   = coord_w(COLS - 1),
  localparam int YW   = coord_w(ROWS - 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          incr,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          frame_end
);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last  = (r_x == XW'(COLS - 1));
  assign w_y_last  = (r_y == YW'(ROWS - 1));
  assign frame_end = w_x_last && w_y_last;
  assign x         = r_x;
  assign y         = r_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (incr) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_filter.sv
// Re-embeds a cropped raster stream at (Y_1, X_1) inside a full frame,
// filling every other position with PAD_VALUE; registered output stage.
module pad_filter
  import crop_pkg::*;
#(
  parameter int                         PIXEL_BIT_WIDTH = 12,
  parameter int                         IN_ROWS         = 20,
  parameter int                         IN_COLS         = 20,
  parameter int                         OUT_ROWS        = 40,
  parameter int                         OUT_COLS        = 40,
  parameter int                         Y_1             = 10,
  parameter int                         X_1             = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] PAD_VALUE       = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);

  localparam int XW = coord_w(OUT_COLS - 1);
  localparam int YW = coord_w(OUT_ROWS - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [XW-1:0]              w_x;
  logic [YW-1:0]              w_y;
  logic                       w_frame_end;
  logic                       w_in_win;
  logic                       w_slot_free;
  logic                       w_load;
  logic                       w_in_ready;
  logic [PIXEL_BIT_WIDTH-1:0] r_pixel_out;
  logic                       r_out_valid;
  logic                       r_out_last;

  raster_counter #(
    .COLS (OUT_COLS),
    .ROWS (OUT_ROWS)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .incr      (w_load),
    .x         (w_x),
    .y         (w_y),
    .frame_end (w_frame_end)
  );

  assign w_in_win    = in_window(int'(w_y), int'(w_x), Y_1, IN_ROWS, X_1, IN_COLS);
  assign w_slot_free = !r_out_valid || out_ready;

  // Window positions wait for input; padding positions load unconditionally.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_next = ACTIVE;
      end
      ACTIVE: begin
        if (w_in_win) begin
          w_in_ready = w_slot_free;
          w_load     = w_slot_free && in_valid;
        end else begin
          w_load = w_slot_free;
        end
        if (w_load && w_frame_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pixel_out <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_pixel_out <= w_in_win ? pixel_in : PAD_VALUE;
      r_out_valid <= 1'b1;
      r_out_last  <= w_frame_end;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign pixel_out = r_pixel_out;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_pad_filter.sv
// Directed bench for pad_filter: a 2x2-in-4x4 instance for the padding
// scenarios and a 4x4 pass-through instance.
module tb_pad_filter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [11:0] a_pixel_in, a_pixel_out;
  logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [11:0] b_pixel_in, b_pixel_out;

  pad_filter #(
    .PIXEL_BIT_WIDTH(12), .IN_ROWS(2), .IN_COLS(2), .OUT_ROWS(4), .OUT_COLS(4),
    .Y_1(1), .X_1(1), .PAD_VALUE(12'hFFF)
  ) u_dut_a (
    .clk(clk), .reset(a_reset), .pixel_in(a_pixel_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .pixel_out(a_pixel_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last)
  );

  pad_filter #(
    .PIXEL_BIT_WIDTH(12), .IN_ROWS(4), .IN_COLS(4), .OUT_ROWS(4), .OUT_COLS(4),
    .Y_1(0), .X_1(0), .PAD_VALUE(12'hABC)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .pixel_in(b_pixel_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .pixel_out(b_pixel_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          rdy_cycles = 0;
  logic        abort = 1'b0;
  logic [11:0] q_pix[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic [11:0] qb_pix[$];
  logic        qb_last[$];
  logic [11:0] exp_a[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted output transfer of both instances.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      q_pix.push_back(a_pixel_out);
      q_last.push_back(a_out_last);
      q_cyc.push_back(cyc);
    end
    if (a_in_ready) rdy_cycles++;
    if (b_out_valid && b_out_ready) begin
      qb_pix.push_back(b_pixel_out);
      qb_last.push_back(b_out_last);
    end
  end

  task automatic clear_a();
    q_pix.delete();
    q_last.delete();
    q_cyc.delete();
    rdy_cycles = 0;
  endtask

  // Presents pixels 1..n; optional gap of gap_len cycles before pixel index gap_at.
  task automatic drive_a(input int n, input int gap_at, input int gap_len);
    int budget;
    for (int k = 0; k < n && !abort; k++) begin
      if (k == gap_at) begin
        a_in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      a_in_valid = 1'b1;
      a_pixel_in = 12'(k + 1);
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!a_in_ready && !abort && budget < 200);
      if (budget >= 200) begin
        n_tests++; n_fail++;
        $display("FAIL drive_a: pixel %0d not accepted, waited %0d cycles, limit 200", k + 1, budget);
      end
      if (!abort) begin
        @(posedge clk);
        #1;
      end
    end
    a_in_valid = 1'b0;
  endtask

  task automatic wait_a(input int n);
    int budget = 0;
    while (q_pix.size() < n && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    n_tests++;
    if (q_pix.size() < n) begin
      n_fail++;
      $display("FAIL wait_a: got %0d outputs, required %0d", q_pix.size(), n);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    a_in_valid = 1'b1;
    a_pixel_in = 12'h055;
    @(negedge clk);
    n_tests += 4;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", a_out_valid); end
    if (a_pixel_out !== 12'h000) begin n_fail++; $display("FAIL rst_pixel: got %h required 000", a_pixel_out); end
    if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b required 0", a_out_last); end
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b required 0", a_in_ready); end
    a_reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_idle_cycle: out_valid got %b required 0", a_out_valid); end
    @(posedge clk);
    #1;
    n_tests += 2;
    if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL rel_first_load: out_valid got %b required 1", a_out_valid); end
    if (a_pixel_out !== 12'hFFF) begin n_fail++; $display("FAIL rel_first_pad: got %h required FFF", a_pixel_out); end
    a_reset = 1'b0;
    #1;
    n_tests += 3;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b required 0", a_out_valid); end
    if (a_pixel_out !== 12'h000) begin n_fail++; $display("FAIL async_pixel: got %h required 000", a_pixel_out); end
    if (u_dut_a.w_x !== 2'd0) begin n_fail++; $display("FAIL async_x: got %0d required 0", u_dut_a.w_x); end
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    a_reset = 1'b1;
    @(posedge clk);
    #1;
    clear_a();
  endtask

  task automatic test_basic();
    logic [11:0] got;
    clear_a();
    drive_a(4, -1, 0);
    wait_a(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < q_pix.size()) ? q_pix[i] : 12'hxxx;
      n_tests += 2;
      if (got !== exp_a[i]) begin n_fail++; $display("FAIL basic_pix[%0d]: got %h required %h", i, got, exp_a[i]); end
      if (i < q_last.size() && q_last[i] !== (i == 15)) begin
        n_fail++; $display("FAIL basic_last[%0d]: got %b required %b", i, q_last[i], i == 15);
      end
    end
    n_tests += 2;
    if (rdy_cycles != 4) begin n_fail++; $display("FAIL basic_in_ready_cycles: got %0d required 4", rdy_cycles); end
    if (q_cyc.size() == 16 && q_cyc[15] - q_cyc[0] != 15) begin
      n_fail++; $display("FAIL basic_rate: span got %0d required 15", q_cyc[15] - q_cyc[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] got;
    clear_a();
    fork
      drive_a(4, -1, 0);
      begin
        int budget = 0;
        while (!(q_pix.size() == 5 && a_out_valid) && budget < 300) begin
          @(posedge clk);
          #1;
          budget++;
        end
        a_out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_tests += 5;
          if (a_pixel_out !== 12'h001) begin n_fail++; $display("FAIL bp_pixel: got %h required 001", a_pixel_out); end
          if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b required 1", a_out_valid); end
          if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", a_in_ready); end
          if (u_dut_a.w_x !== 2'd2) begin n_fail++; $display("FAIL bp_x: got %0d required 2", u_dut_a.w_x); end
          if (u_dut_a.w_y !== 2'd1) begin n_fail++; $display("FAIL bp_y: got %0d required 1", u_dut_a.w_y); end
          @(posedge clk);
          #1;
        end
        a_out_ready = 1'b1;
      end
    join
    wait_a(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < q_pix.size()) ? q_pix[i] : 12'hxxx;
      n_tests++;
      if (got !== exp_a[i]) begin n_fail++; $display("FAIL bp_seq[%0d]: got %h required %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_gap();
    logic [11:0] got;
    clear_a();
    drive_a(4, 2, 4);
    wait_a(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < q_pix.size()) ? q_pix[i] : 12'hxxx;
      n_tests++;
      if (got !== exp_a[i]) begin n_fail++; $display("FAIL gap_seq[%0d]: got %h required %h", i, got, exp_a[i]); end
    end
    n_tests++;
    if (q_cyc.size() == 16 && q_cyc[9] - q_cyc[8] != 3) begin
      n_fail++; $display("FAIL gap_stall: idx8->idx9 distance got %0d required 3", q_cyc[9] - q_cyc[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] got;
    clear_a();
    fork
      drive_a(4, -1, 0);
      begin
        int budget = 0;
        while (q_pix.size() < 7 && budget < 300) begin
          @(posedge clk);
          #1;
          budget++;
        end
        n_tests++;
        if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b required 1", a_out_valid); end
        a_reset = 1'b0;
        #1;
        n_tests += 3;
        if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b required 0", a_out_valid); end
        if (a_pixel_out !== 12'h000) begin n_fail++; $display("FAIL mid_pixel: got %h required 000", a_pixel_out); end
        if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL mid_last: got %b required 0", a_out_last); end
        abort = 1'b1;
      end
    join
    @(posedge clk);
    #1;
    abort = 1'b0;
    a_reset = 1'b1;
    clear_a();
    drive_a(4, -1, 0);
    wait_a(16);
    for (int i = 0; i < 16; i++) begin
      got = (i < q_pix.size()) ? q_pix[i] : 12'hxxx;
      n_tests++;
      if (got !== exp_a[i]) begin n_fail++; $display("FAIL mid_seq[%0d]: got %h required %h", i, got, exp_a[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got, want;
    clear_a();
    drive_a(8, -1, 0);
    wait_a(32);
    for (int i = 0; i < 32; i++) begin
      want = exp_a[i % 16];
      if (i >= 16 && want != 12'hFFF) want = want + 12'd4;
      got = (i < q_pix.size()) ? q_pix[i] : 12'hxxx;
      n_tests += 2;
      if (got !== want) begin n_fail++; $display("FAIL b2b_pix[%0d]: got %h required %h", i, got, want); end
      if (i < q_last.size() && q_last[i] !== (i == 15 || i == 31)) begin
        n_fail++; $display("FAIL b2b_last[%0d]: got %b required %b", i, q_last[i], i == 15 || i == 31);
      end
    end
    n_tests++;
    if (q_cyc.size() == 32 && q_cyc[16] - q_cyc[15] != 2) begin
      n_fail++; $display("FAIL b2b_bubble: distance got %0d required 2", q_cyc[16] - q_cyc[15]);
    end
    n_tests++;
    if (q_cyc.size() == 32 && q_cyc[31] - q_cyc[16] != 15) begin
      n_fail++; $display("FAIL b2b_rate: span got %0d required 15", q_cyc[31] - q_cyc[16]);
    end
  endtask

  task automatic test_passthrough();
    int budget;
    logic [11:0] got;
    b_reset = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      b_in_valid = 1'b1;
      b_pixel_in = 12'(k);
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!b_in_ready && budget < 200);
      if (budget >= 200) begin
        n_tests++; n_fail++;
        $display("FAIL pt_drive: pixel %0d not accepted, waited %0d cycles", k, budget);
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    budget = 0;
    while (qb_pix.size() < 16 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    n_tests++;
    if (qb_pix.size() != 16) begin n_fail++; $display("FAIL pt_count: got %0d required 16", qb_pix.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < qb_pix.size()) ? qb_pix[i] : 12'hxxx;
      n_tests += 2;
      if (got !== 12'(i)) begin n_fail++; $display("FAIL pt_pix[%0d]: got %h required %h", i, got, 12'(i)); end
      if (i < qb_last.size() && qb_last[i] !== (i == 15)) begin
        n_fail++; $display("FAIL pt_last[%0d]: got %b required %b", i, qb_last[i], i == 15);
      end
    end
  endtask

  initial begin
    exp_a = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF,
              12'hFFF, 12'h001, 12'h002, 12'hFFF,
              12'hFFF, 12'h003, 12'h004, 12'hFFF,
              12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};
    a_reset = 1'b0; a_in_valid = 1'b0; a_pixel_in = '0; a_out_ready = 1'b1;
    b_reset = 1'b0; b_in_valid = 1'b0; b_pixel_in = '0; b_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_passthrough();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
